// File: rtl/demux_ctrl.sv
// Sequencing controller for the 1-to-4 demux: one-entry hold buffer, per-lane
// pause handling, registered demux drive and per-lane fire counters.
module demux_ctrl #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  init,
  input  logic                  valid_in,
  input  logic [1:0]            dest_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  input  logic [3:0]            pausa,
  output logic                  enb_dmux,
  output logic [1:0]            selector_dmux,
  output logic [DATA_WIDTH-1:0] entrada_dmux,
  input  logic                  req_cnt,
  input  logic [1:0]            idx_cnt,
  input  logic                  clr_cnt,
  output logic [CNT_WIDTH-1:0]  contador,
  output logic                  contador_valid,
  output logic                  idle
);

  localparam int unsigned NUM_LANES = 4;

  typedef enum logic [1:0] {
    ST_INICIO = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVO = 2'd2,
    ST_PAUSA  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_hold_dest;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [CNT_WIDTH-1:0]  r_cnt [NUM_LANES];

  logic w_lane_paused;
  logic w_fire;
  logic w_accept;

  // Only the lane of the held word can stall it.
  assign w_lane_paused = pausa[r_hold_dest];
  assign w_fire        = (r_state == ST_ACTIVO) && !w_lane_paused;
  assign ready_out     = (r_state == ST_IDLE) || w_fire;
  assign w_accept      = valid_in && ready_out;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INICIO: if (init)     w_state_nxt = ST_IDLE;
      ST_IDLE:   if (w_accept) w_state_nxt = ST_ACTIVO;
      ST_ACTIVO: begin
        if (w_lane_paused)  w_state_nxt = ST_PAUSA;
        else if (!w_accept) w_state_nxt = ST_IDLE;
      end
      ST_PAUSA:  if (!w_lane_paused) w_state_nxt = ST_ACTIVO;
      default:   w_state_nxt = ST_INICIO;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state        <= ST_INICIO;
      r_hold_dest    <= 2'd0;
      r_hold_data    <= '0;
      r_cnt          <= '{default: '0};
      idle           <= 1'b0;
      enb_dmux       <= 1'b0;
      selector_dmux  <= 2'd0;
      entrada_dmux   <= '0;
      contador       <= '0;
      contador_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      idle    <= (w_state_nxt == ST_IDLE);

      if (w_accept) begin
        r_hold_dest <= dest_in;
        r_hold_data <= data_in;
      end

      enb_dmux <= w_fire;
      if (w_fire) begin
        selector_dmux <= r_hold_dest;
        entrada_dmux  <= r_hold_data;
      end

      // Clear wins over a coincident fire; the fired word is then not counted.
      if (clr_cnt) begin
        r_cnt <= '{default: '0};
      end else if (w_fire) begin
        r_cnt[r_hold_dest] <= r_cnt[r_hold_dest] + CNT_WIDTH'(1);
      end

      contador_valid <= req_cnt;
      if (req_cnt) begin
        contador <= r_cnt[idx_cnt];
      end
    end
  end

endmodule

// File: tb/tb_demux_ctrl.sv
// Scoreboard bench for demux_ctrl: accepted words are queued in order and
// matched against demux emissions; per-lane counts are tracked in plain ints.
module tb_demux_ctrl;

  localparam int unsigned DW = 6;
  localparam int unsigned CW = 5;
  localparam int CNT_MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          init;
  logic          valid_in;
  logic [1:0]    dest_in;
  logic [DW-1:0] data_in;
  logic          ready_out;
  logic [3:0]    pausa;
  logic          enb_dmux;
  logic [1:0]    selector_dmux;
  logic [DW-1:0] entrada_dmux;
  logic          req_cnt;
  logic [1:0]    idx_cnt;
  logic          clr_cnt;
  logic [CW-1:0] contador;
  logic          contador_valid;
  logic          idle;

  demux_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .valid_in(valid_in), .dest_in(dest_in), .data_in(data_in),
    .ready_out(ready_out), .pausa(pausa),
    .enb_dmux(enb_dmux), .selector_dmux(selector_dmux), .entrada_dmux(entrada_dmux),
    .req_cnt(req_cnt), .idx_cnt(idx_cnt), .clr_cnt(clr_cnt),
    .contador(contador), .contador_valid(contador_valid), .idle(idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW+1:0] exp_q[$];
  int  cnt_m[4];
  bit  skip_cnt = 1'b0;
  bit  last_ready;
  int  enb_run = 0;
  int  max_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every demux emission must be the oldest outstanding accepted word.
  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (enb_dmux === 1'b1) begin
      enb_run++;
      if (enb_run > max_run) max_run = enb_run;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL emit_unexpected actual=sel%0d/0x%0h required=none", selector_dmux, entrada_dmux);
      end else begin
        e = exp_q.pop_front();
        if ({selector_dmux, entrada_dmux} !== e) begin
          errors++;
          $display("FAIL emit_word actual=sel%0d/0x%0h required=sel%0d/0x%0h",
                   selector_dmux, entrada_dmux, e[DW+1:DW], e[DW-1:0]);
        end
      end
      if (skip_cnt) skip_cnt = 1'b0;
      else cnt_m[selector_dmux] = (cnt_m[selector_dmux] + 1) % CNT_MOD;
    end else begin
      enb_run = 0;
    end
  end

  // One cycle: sample handshake before the edge, return just after it.
  task automatic tick();
    @(negedge clk);
    last_ready = ready_out;
    if (reset_L && valid_in && ready_out) exp_q.push_back({dest_in, data_in});
    if (reset_L && clr_cnt) foreach (cnt_m[i]) cnt_m[i] = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("init_idle", 32'(idle), 32'd1);
    chk("init_ready", 32'(ready_out), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    valid_in = 1'b0;
    pausa    = 4'b0000;
    while ((exp_q.size() != 0 || idle !== 1'b1) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < 100), 32'd1);
  endtask

  task automatic read_cnt(input int lane);
    logic [CW-1:0] held;
    drain();
    req_cnt = 1'b1;
    idx_cnt = 2'(lane);
    tick();
    req_cnt = 1'b0;
    chk($sformatf("cnt_valid_l%0d", lane), 32'(contador_valid), 32'd1);
    chk($sformatf("cnt_value_l%0d", lane), 32'(contador), 32'(cnt_m[lane]));
    held = contador;
    tick();
    chk("cnt_valid_drop", 32'(contador_valid), 32'd0);
    chk("cnt_hold", 32'(contador), 32'(held));
  endtask

  task automatic send(input logic [1:0] d, input logic [DW-1:0] v);
    valid_in = 1'b1;
    dest_in  = d;
    data_in  = v;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic clear_counters();
    drain();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset_L = 1'b0; init = 1'b0; valid_in = 1'b0; dest_in = 2'd0; data_in = '0;
    pausa = 4'b0000; req_cnt = 1'b0; idx_cnt = 2'd0; clr_cnt = 1'b0;
    foreach (cnt_m[i]) cnt_m[i] = 0;

    // Reset and init
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {20'd0, enb_dmux, selector_dmux, entrada_dmux, contador_valid, idle},
        32'd0);
    chk("rst_contador", 32'(contador), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd0);
    reset_L = 1'b1;
    valid_in = 1'b1;
    repeat (3) tick();
    chk("inicio_ready", 32'(last_ready), 32'd0);
    chk("inicio_idle", 32'(idle), 32'd0);
    chk("inicio_no_accept", 32'(exp_q.size()), 32'd0);
    valid_in = 1'b0;
    do_init();

    // Single word, one-edge latency
    send(2'd2, 6'h2A);
    chk("single_not_yet", 32'(enb_dmux), 32'd0);
    tick();
    chk("single_enb", 32'(enb_dmux), 32'd1);
    chk("single_sel", 32'(selector_dmux), 32'd2);
    chk("single_data", 32'(entrada_dmux), 32'h2A);
    chk("single_idle", 32'(idle), 32'd1);
    tick();
    chk("single_one_cycle", 32'(enb_dmux), 32'd0);
    read_cnt(2);

    // Streaming 8 words back to back
    clear_counters();
    max_run = 0;
    valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dest_in = 2'(i % 4);
      data_in = DW'(i * 7 + 3);
      tick();
      chk("stream_ready", 32'(last_ready), 32'd1);
    end
    drain();
    chk("stream_run", 32'(max_run), 32'd8);
    for (int l = 0; l < 4; l++) read_cnt(l);

    // Pause on held lane, unrelated lanes ignored
    send(2'd1, 6'h15);
    pausa = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pause_ready", 32'(last_ready), 32'd0);
      chk("pause_enb", 32'(enb_dmux), 32'd0);
      chk("pause_idle", 32'(idle), 32'd0);
    end
    pausa = 4'b1101;
    tick();
    chk("unpause_no_fire_yet", 32'(enb_dmux), 32'd0);
    tick();
    chk("unpause_ready", 32'(last_ready), 32'd1);
    chk("unpause_enb", 32'(enb_dmux), 32'd1);
    chk("unpause_sel", 32'(selector_dmux), 32'd1);
    drain();
    read_cnt(1);

    // Counter wrap on lane 3
    clear_counters();
    valid_in = 1'b1;
    dest_in  = 2'd3;
    for (int i = 0; i < CNT_MOD; i++) begin
      data_in = DW'($urandom);
      tick();
    end
    drain();
    read_cnt(3);

    // Clear coinciding with a fire
    send(2'd1, 6'h11);
    drain();
    send(2'd0, 6'h3C);
    clr_cnt  = 1'b1;
    skip_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clrfire_enb", 32'(enb_dmux), 32'd1);
    chk("clrfire_data", 32'(entrada_dmux), 32'h3C);
    read_cnt(0);
    read_cnt(1);

    // Randomized traffic with random pauses and ignored init pulses
    for (int i = 0; i < 400; i++) begin
      valid_in = ($urandom_range(0, 9) < 7);
      dest_in  = 2'($urandom_range(0, 3));
      data_in  = DW'($urandom);
      pausa    = 4'($urandom) & 4'($urandom);
      init     = ($urandom_range(0, 19) == 0);
      tick();
    end
    init = 1'b0;
    drain();
    for (int l = 0; l < 4; l++) read_cnt(l);

    // Reset while a word is paused in hold
    send(2'd2, 6'h07);
    pausa = 4'b0100;
    repeat (3) tick();
    reset_L = 1'b0;
    #1;
    exp_q.delete();
    foreach (cnt_m[i]) cnt_m[i] = 0;
    chk("midrst_outputs", {20'd0, enb_dmux, selector_dmux, entrada_dmux, contador_valid, idle},
        32'd0);
    chk("midrst_ready", 32'(ready_out), 32'd0);
    tick();
    reset_L = 1'b1;
    pausa = 4'b0000;
    tick();
    chk("midrst_inicio_ready", 32'(ready_out), 32'd0);
    do_init();
    repeat (6) tick();
    chk("midrst_no_emit", 32'(enb_dmux), 32'd0);
    read_cnt(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
